// File: rtl/mos6502_tgt_pkg.sv
// Shared constants and types for the MOS6502 bus target: window geometry,
// register offsets, CTRL/STATUS bit positions and the wait-state FSM encoding.
package mos6502_tgt_pkg;

    localparam int WIN_AW    = 7;
    localparam int RAM_AW    = 6;
    localparam int RAM_BYTES = 1 << RAM_AW;

    localparam logic [3:0] REG_RLD_LO = 4'h0;
    localparam logic [3:0] REG_RLD_HI = 4'h1;
    localparam logic [3:0] REG_CTRL   = 4'h2;
    localparam logic [3:0] REG_STATUS = 4'h3;
    localparam logic [3:0] REG_CNT_LO = 4'h4;
    localparam logic [3:0] REG_CNT_HI = 4'h5;
    localparam logic [3:0] REG_WDOG   = 4'h6;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_AUTO = 2;
    localparam int STAT_EXP  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } tgt_state_e;

endpackage

// File: rtl/mos6502_tgt_timer.sv
// 16-bit interval timer: reload/count/CTRL/EXP state with strobed register
// writes from the bus target and a single-cycle expiry pulse.
module mos6502_tgt_timer
    import mos6502_tgt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_rld_lo,
    input  logic        wr_rld_hi,
    input  logic        wr_ctrl,
    input  logic        wr_status,
    input  logic [7:0]  wdata,
    output logic [15:0] reload,
    output logic [15:0] count,
    output logic [2:0]  ctrl,
    output logic        exp,
    output logic        expire
);

    assign expire = ctrl[CTRL_EN] && (count == 16'h0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= '0;
            count  <= '0;
            ctrl   <= '0;
            exp    <= 1'b0;
        end else begin
            if (wr_rld_lo) reload[7:0]  <= wdata;
            if (wr_rld_hi) reload[15:8] <= wdata;

            if (wr_ctrl && wdata[CTRL_EN] && !ctrl[CTRL_EN]) begin
                count <= reload;
            end else if (expire) begin
                if (ctrl[CTRL_AUTO]) count <= reload;
            end else if (ctrl[CTRL_EN]) begin
                count <= count - 16'd1;
            end

            // A CTRL write overrides the one-shot auto-disable in the same cycle.
            if (wr_ctrl) begin
                ctrl <= wdata[2:0];
            end else if (expire && !ctrl[CTRL_AUTO]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            // Expiry beats a simultaneous write-1-to-clear.
            if (expire) begin
                exp <= 1'b1;
            end else if (wr_status && wdata[STAT_EXP]) begin
                exp <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mos6502_bus_target.sv
// Bus responder for the 6502 core: 64-byte scratch RAM plus a timer register
// bank with RDY wait states. Optional watchdog/NMI via MOS6502_TGT_WDOG_EN.
//
//   state  | meaning
//   IDLE   | no stall; register decode drops RDY when WAIT_CYCLES > 0
//   WAIT   | RDY low, counting remaining wait cycles
//   ACCESS | RDY high, register access taken on this edge
module mos6502_bus_target
    import mos6502_tgt_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFE00,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        hit,
    output logic        RDY,
    output logic        IRQ,
    output logic        NMI
);

    localparam logic [1:0] WAIT_LOAD = 2'(WAIT_CYCLES - 1);

    tgt_state_e  state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        win_sel, ram_sel, reg_sel;
    logic        rdy_c, taken, rd_taken, wr_taken, wr_reg;
    logic [3:0]  reg_off;
    logic [7:0]  ram [RAM_BYTES];
    logic [7:0]  rd_data, snapshot;
    logic [15:0] reload, count;
    logic [2:0]  ctrl;
    logic        exp, expire_unused;

    assign win_sel  = (AB[15:WIN_AW] == BASE_ADDR[15:WIN_AW]);
    assign ram_sel  = win_sel && !AB[6];
    assign reg_sel  = win_sel && (AB[6:4] == 3'b100);
    assign reg_off  = AB[3:0];

    assign taken    = win_sel && rdy_c;
    assign rd_taken = taken && !WE;
    assign wr_taken = taken && WE;
    assign wr_reg   = wr_taken && reg_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RDY is low for exactly WAIT_CYCLES cycles, the IDLE decode cycle included.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdy_c     = 1'b1;
        case (state)
            IDLE: begin
                if (reg_sel && (WAIT_CYCLES != 0)) begin
                    rdy_c     = 1'b0;
                    cnt_nxt   = WAIT_LOAD;
                    state_nxt = (WAIT_CYCLES == 1) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                rdy_c   = 1'b0;
                cnt_nxt = cnt - 2'd1;
                if (cnt == 2'd1) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset releases a stalled core at once, even with AB still on a register.
    assign RDY = rdy_c | reset;

`ifdef MOS6502_TGT_WDOG_EN
    logic [15:0] wdog;
    logic        wdog_armed, nmi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog       <= '0;
            wdog_armed <= 1'b0;
            nmi_q      <= 1'b0;
        end else begin
            nmi_q <= 1'b0;
            if (wr_reg && (reg_off == REG_WDOG)) begin
                wdog       <= 16'hFFFF;
                wdog_armed <= 1'b1;
            end else if (wdog_armed) begin
                if (wdog == 16'h0000) begin
                    nmi_q <= 1'b1;
                    wdog  <= 16'hFFFF;
                end else begin
                    wdog <= wdog - 16'd1;
                end
            end
        end
    end

    assign NMI = nmi_q;
`else
    assign NMI = 1'b0;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (ram_sel) begin
            rd_data = ram[AB[RAM_AW-1:0]];
        end else if (reg_sel) begin
            case (reg_off)
                REG_RLD_LO: rd_data = reload[7:0];
                REG_RLD_HI: rd_data = reload[15:8];
                REG_CTRL:   rd_data = {5'b0, ctrl};
                REG_STATUS: rd_data = {7'b0, exp};
                REG_CNT_LO: rd_data = count[7:0];
                REG_CNT_HI: rd_data = snapshot;
`ifdef MOS6502_TGT_WDOG_EN
                REG_WDOG:   rd_data = {7'b0, wdog_armed};
`endif
                default:    rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_taken && ram_sel) ram[AB[RAM_AW-1:0]] <= DO;
    end

    // DI holds its last read value until the next taken read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            DI       <= 8'h00;
            hit      <= 1'b0;
            snapshot <= 8'h00;
        end else begin
            hit <= rd_taken;
            if (rd_taken) DI <= rd_data;
            if (rd_taken && reg_sel && (reg_off == REG_CNT_LO)) snapshot <= count[15:8];
        end
    end

    mos6502_tgt_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_rld_lo (wr_reg && (reg_off == REG_RLD_LO)),
        .wr_rld_hi (wr_reg && (reg_off == REG_RLD_HI)),
        .wr_ctrl   (wr_reg && (reg_off == REG_CTRL)),
        .wr_status (wr_reg && (reg_off == REG_STATUS)),
        .wdata     (DO),
        .reload    (reload),
        .count     (count),
        .ctrl      (ctrl),
        .exp       (exp),
        .expire    (expire_unused)
    );

    assign IRQ = exp & ctrl[CTRL_IE];

endmodule

// File: tb/tb_mos6502_bus_target.sv
// Directed bench for mos6502_bus_target with WAIT_CYCLES=2.
module tb_mos6502_bus_target;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] AB = 16'h0000;
    logic [7:0]  DO = 8'h00;
    logic        WE = 1'b0;
    logic [7:0]  DI;
    logic        hit, RDY, IRQ, NMI;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_taken = 0;

    logic [7:0] rv;
    logic       hv;
    int         sv;

    mos6502_bus_target #(.BASE_ADDR(16'hFE00), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE),
        .DI(DI), .hit(hit), .RDY(RDY), .IRQ(IRQ), .NMI(NMI)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one access, holding AB/WE/DO while RDY is low; returns DI/hit as
    // seen in the cycle after the taken edge and the number of stall cycles.
    task automatic bus(input logic [15:0] a, input logic we, input logic [7:0] d,
                       output logic [7:0] r, output logic h, output int stalls);
        AB = a; WE = we; DO = d; stalls = 0;
        @(negedge clk);
        while (RDY !== 1'b1 && stalls < 16) begin
            stalls++;
            @(negedge clk);
        end
        if (RDY !== 1'b1) begin
            errors++;
            $display("FAIL bus_timeout: addr %h RDY still %b after %0d cycles, required 1", a, RDY, stalls);
        end
        @(posedge clk); #1;
        last_taken = cyc;
        AB = 16'h0000; WE = 1'b0; DO = 8'h00;
        @(negedge clk);
        r = DI; h = hit;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (DI !== 8'h00) begin errors++; $display("FAIL reset_di: got %h required 00", DI); end
        checks++;
        if ({hit, RDY, IRQ, NMI} !== 4'b0100)
            begin errors++; $display("FAIL reset_flags: hit/RDY/IRQ/NMI got %b required 0100", {hit, RDY, IRQ, NMI}); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ram;
        bus(16'hFE05, 1'b1, 8'hA5, rv, hv, sv);
        checks++;
        if (sv !== 0) begin errors++; $display("FAIL ram_wr_stall: got %0d required 0", sv); end
        bus(16'hFE05, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if ({hv, rv} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL ram_rd: hit/DI got %b/%h required 1/a5", hv, rv); end
        checks++;
        if (sv !== 0) begin errors++; $display("FAIL ram_rd_stall: got %0d required 0", sv); end
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL ram_hit_width: got %b required 0", hit); end
        bus(16'hFE3F, 1'b1, 8'h3C, rv, hv, sv);
        bus(16'hFE3F, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if ({hv, rv} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL ram_top: hit/DI got %b/%h required 1/3c", hv, rv); end
    endtask

    task automatic test_decode;
        bus(16'hFE20, 1'b1, 8'h11, rv, hv, sv);
        bus(16'hFE60, 1'b1, 8'h77, rv, hv, sv);
        bus(16'hFE20, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (rv !== 8'h11) begin errors++; $display("FAIL unused_wr_alias: got %h required 11", rv); end
        bus(16'hFE60, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if ({hv, rv} !== {1'b1, 8'h00}) begin errors++; $display("FAIL unused_rd: hit/DI got %b/%h required 1/00", hv, rv); end
        bus(16'hFE80, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (hv !== 1'b0) begin errors++; $display("FAIL miss_above: hit got %b required 0", hv); end
        bus(16'hFDFF, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (hv !== 1'b0) begin errors++; $display("FAIL miss_below: hit got %b required 0", hv); end
        bus(16'hFE47, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if ({hv, rv} !== {1'b1, 8'h00}) begin errors++; $display("FAIL reg7_rd: hit/DI got %b/%h required 1/00", hv, rv); end
        bus(16'hFE46, 1'b1, 8'h5A, rv, hv, sv);
        bus(16'hFE46, 1'b0, 8'h00, rv, hv, sv);
        checks++;
`ifdef MOS6502_TGT_WDOG_EN
        if (rv !== 8'h01) begin errors++; $display("FAIL wdog_armed_rd: got %h required 01", rv); end
`else
        if (rv !== 8'h00) begin errors++; $display("FAIL reg6_rd: got %h required 00", rv); end
`endif
    endtask

    task automatic test_wait_states;
        bus(16'hFE42, 1'b1, 8'hF6, rv, hv, sv);
        checks++;
        if (sv !== 2) begin errors++; $display("FAIL wait_wr_stall: got %0d required 2", sv); end
        bus(16'hFE42, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (sv !== 2) begin errors++; $display("FAIL wait_rd_stall: got %0d required 2", sv); end
        checks++;
        if ({hv, rv} !== {1'b1, 8'h06}) begin errors++; $display("FAIL ctrl_rd: hit/DI got %b/%h required 1/06", hv, rv); end
    endtask

    task automatic test_timer_auto;
        int t0, ts, first_e;
        bus(16'hFE40, 1'b1, 8'h03, rv, hv, sv);
        bus(16'hFE41, 1'b1, 8'h00, rv, hv, sv);
        bus(16'hFE42, 1'b1, 8'h07, rv, hv, sv);
        t0 = last_taken;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (IRQ !== ((cyc - t0) >= 4))
                begin errors++; $display("FAIL irq_rise: cycle +%0d got %b required %b", cyc - t0, IRQ, (cyc - t0) >= 4); end
        end
        @(posedge clk); #1;
        bus(16'hFE43, 1'b1, 8'h01, rv, hv, sv);
        ts = last_taken;
        checks++;
        if (ts !== t0 + 10) begin errors++; $display("FAIL status_wr_edge: got +%0d required +10", ts - t0); end
        first_e = t0 + 4 * ((ts - t0 + 3) / 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (IRQ !== (cyc >= first_e))
                begin errors++; $display("FAIL irq_clear: cycle +%0d got %b required %b", cyc - t0, IRQ, cyc >= first_e); end
        end
        @(posedge clk); #1;
        while (cyc < t0 + 17) begin @(posedge clk); #1; end
        bus(16'hFE43, 1'b1, 8'h01, rv, hv, sv);
        ts = last_taken;
        first_e = t0 + 4 * ((ts - t0 + 3) / 4);
        @(negedge clk);
        checks++;
        if (IRQ !== (cyc >= first_e))
            begin errors++; $display("FAIL irq_set_wins: cycle +%0d got %b required %b", cyc - t0, IRQ, cyc >= first_e); end
        @(posedge clk); #1;
        bus(16'hFE42, 1'b1, 8'h00, rv, hv, sv);
        bus(16'hFE43, 1'b1, 8'h01, rv, hv, sv);
        bus(16'hFE43, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL status_cleared: got %h required 00", rv); end
    endtask

    task automatic test_one_shot;
        bus(16'hFE40, 1'b1, 8'h00, rv, hv, sv);
        bus(16'hFE41, 1'b1, 8'h00, rv, hv, sv);
        bus(16'hFE42, 1'b1, 8'h03, rv, hv, sv);
        @(negedge clk);
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL oneshot_irq: got %b required 1", IRQ); end
        @(posedge clk); #1;
        bus(16'hFE42, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (rv !== 8'h02) begin errors++; $display("FAIL oneshot_en_clear: CTRL got %h required 02", rv); end
        bus(16'hFE44, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL oneshot_count_hold: got %h required 00", rv); end
        bus(16'hFE43, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (rv !== 8'h01) begin errors++; $display("FAIL oneshot_status: got %h required 01", rv); end
    endtask

    task automatic test_atomic_read;
        int ta;
        logic [15:0] live;
        bus(16'hFE40, 1'b1, 8'h03, rv, hv, sv);
        bus(16'hFE41, 1'b1, 8'h01, rv, hv, sv);
        bus(16'hFE42, 1'b1, 8'h01, rv, hv, sv);
        ta = last_taken;
        bus(16'hFE44, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL cnt_lo_0100: got %h required 00", rv); end
        repeat (10) @(posedge clk);
        #1;
        bus(16'hFE45, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (rv !== 8'h01) begin errors++; $display("FAIL cnt_hi_snapshot: got %h required 01", rv); end
        bus(16'hFE44, 1'b0, 8'h00, rv, hv, sv);
        live = 16'h0103 - 16'(last_taken - ta - 1);
        checks++;
        if (rv !== live[7:0]) begin errors++; $display("FAIL cnt_lo_live: got %h required %h", rv, live[7:0]); end
        bus(16'hFE45, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if (rv !== live[15:8]) begin errors++; $display("FAIL cnt_hi_resnap: got %h required %h", rv, live[15:8]); end
    endtask

    task automatic test_reset_mid_wait;
        bus(16'hFE05, 1'b0, 8'h00, rv, hv, sv);
        AB = 16'hFE42; WE = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({RDY, DI} !== {1'b0, 8'hA5}) begin errors++; $display("FAIL pre_reset_wait: RDY/DI got %b/%h required 0/a5", RDY, DI); end
        reset = 1'b1;
        #1;
        checks++;
        if ({RDY, DI, hit, IRQ, NMI} !== {1'b1, 8'h00, 3'b000})
            begin errors++; $display("FAIL async_reset: RDY/DI/hit/IRQ/NMI got %b/%h/%b/%b/%b required 1/00/0/0/0", RDY, DI, hit, IRQ, NMI); end
        AB = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        bus(16'hFE42, 1'b0, 8'h00, rv, hv, sv);
        checks++;
        if ({sv, rv} !== {32'd2, 8'h00}) begin errors++; $display("FAIL post_reset_ctrl: stalls/CTRL got %0d/%h required 2/00", sv, rv); end
    endtask

`ifdef MOS6502_TGT_WDOG_EN
    task automatic test_wdog;
        int tw, pulses, first;
        bus(16'hFE46, 1'b1, 8'h00, rv, hv, sv);
        tw = last_taken;
        pulses = 0;
        first = -1;
        while (cyc < tw + 65540) begin
            @(negedge clk);
            if (NMI === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL nmi_pulses: got %0d required 1", pulses); end
        checks++;
        if (first !== tw + 65536) begin errors++; $display("FAIL nmi_time: got +%0d required +65536", first - tw); end
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_decode();
        test_wait_states();
        test_timer_auto();
        test_one_shot();
        test_atomic_read();
        test_reset_mid_wait();
`ifdef MOS6502_TGT_WDOG_EN
        test_wdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mos6502_bus_target.md
Name: mos6502_bus_target

Overview:
- Bus responder for the MOS6502 core: the target end of the core's AB/DO/WE/DI/RDY/IRQ interface.
- Decodes a 128-byte window at BASE_ADDR. Contains 64 bytes of scratch RAM (zero wait) and a 16-bit interval timer register bank (WAIT_CYCLES wait states via RDY).
- Drives IRQ back to the core; a top-level mux selects DI from this block whenever hit is high.

Parameters:
- BASE_ADDR, 16'hFE00, window base; must be 128-byte aligned.
- WAIT_CYCLES, 1, RDY-low cycles inserted per register-bank access (0..3).

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- AB  input  16  address from core.
- DO  input  8  write data from core.
- WE  input  1  write enable from core, high = write.
- DI  output  8  read data to core; registered.
- hit  output  1  registered; high in the cycle DI carries this block's data.
- RDY  output  1  core ready; low stalls the core.
- IRQ  output  1  level interrupt request, active-high.
- NMI  output  1  non-maskable request; tied 0 unless MOS6502_TGT_WDOG_EN is defined.

Behaviour:
- Reset values: DI=0, hit=0, RDY=1, IRQ=0, NMI=0, FSM=IDLE. Timer count, reload, CTRL, STATUS and snapshot all 0; RAM contents undefined.
- Decode:
  - AB[15:7]==BASE_ADDR[15:7] selects the window.
  - AB[6]=0 selects RAM[AB[5:0]].
  - AB[6:4]=3'b100 selects registers by AB[3:0].
  - Other offsets read 8'h00; writes to them are ignored.
- Protocol: while RDY=0 the core holds AB, WE and DO stable. An access is taken on a clk edge where it is decoded and RDY=1.
- Reads: DI and hit are valid in the cycle after the taken edge (1-cycle latency). hit is 0 for non-decoded addresses.
- Writes: committed on the taken edge.
- RAM accesses: RDY stays 1.
- Register-bank FSM:
  - IDLE: on a register decode with WAIT_CYCLES>0, drop RDY and go to WAIT with cnt=WAIT_CYCLES-1.
  - WAIT: RDY=0; decrement cnt. At cnt==0, go to ACCESS.
  - ACCESS: RDY=1; the access is taken; return to IDLE.
  - WAIT_CYCLES=0: no stall.
- Registers:
  - 0x0 RLD_LO, 0x1 RLD_HI: reload value, R/W.
  - 0x2 CTRL: bit0 EN, bit1 IE, bit2 AUTO; R/W; other bits read 0.
  - 0x3 STATUS: bit0 EXP; write-1-to-clear.
  - 0x4 CNT_LO: read-only. Reading it latches CNT_HI into a snapshot.
  - 0x5 CNT_HI: read-only; returns the snapshot.
- Timer (16-bit down-counter, counts every clk, not gated by RDY):
  - A CTRL write that sets EN from 0 to 1 loads count from reload.
  - While EN=1 and count==0: expiry event. EXP sets; if AUTO, count reloads, else EN clears.
  - Period is reload+1 cycles; reload=0 expires every cycle.
- IRQ = EXP & IE, combinationally registered from state (no extra latency beyond EXP).
- Simultaneous events:
  - Expiry in the same cycle as a STATUS write-1-clear: set wins.
  - CTRL write in the same cycle as expiry: the written EN value wins.
- Reset mid-access: FSM returns to IDLE and RDY=1 immediately (asynchronous).

Optional Feature:
- Macro: MOS6502_TGT_WDOG_EN.
- Defined:
  - Adds a 16-bit watchdog at register 0x6; any write reloads it to 16'hFFFF.
  - It decrements every clk after the first write.
  - At 0 it pulses NMI high for exactly 1 cycle, then reloads.
  - Register 0x6 reads as bit0 = armed.
- Undefined: NMI tied 0; register 0x6 behaves as an unused offset.

Decomposition:
- Package mos6502_tgt_pkg:
  - register offset constants;
  - CTRL/STATUS bit indices;
  - FSM state enum {IDLE, WAIT, ACCESS};
  - window/RAM size constants.
- Sub-module mos6502_tgt_timer: count/reload/EXP/AUTO logic, with strobed write inputs and an expiry pulse output.
- Decode, FSM, RAM and the DI mux stay in the top level.

Test Plan:
- RAM: write 8'hA5 to FE05 (WE=1), then read FE05 -> DI=8'hA5 with hit=1 exactly one cycle after the read edge; RDY stays 1 throughout.
- Wait states, WAIT_CYCLES=2: read FE42 -> RDY low for 2 cycles, taken on the 3rd edge, DI=CTRL on the next cycle; AB held during the stall.
- Timer: reload=3, CTRL=3'b111 -> EXP and IRQ rise 4 cycles after the enable edge and recur every 4 cycles. Write STATUS=1 -> IRQ drops the next cycle unless it coincides with an expiry.
- One-shot: CTRL=3'b011, reload=0 -> EXP sets once, EN reads back 0; count holds.
- Atomic read: with count at 16'h0100 -> read CNT_LO=8'h00, wait 10 cycles, read CNT_HI -> 8'h01 (snapshot, not live).
- Async reset asserted mid-WAIT -> RDY=1 and DI=0 immediately; with MOS6502_TGT_WDOG_EN, NMI pulses once 65536 cycles after a write to FE46.
